// File: rtl/sign_result_accumulator.sv
// Block-sum reducer for the signed add/sub result stream.
// Saturating wide accumulator with valid/ready on both sides.
//
// Ports:
//   Clk, ResetN       clock, async active-low reset
//   Clear             synchronous abort back to IDLE
//   BlockLength       samples per block (0 treated as 1)
//   InValid/InReady   input handshake, InData signed sample
//   OutValid/OutReady output handshake
//   OutSum            signed saturated block sum
//   OutCount          number of samples summed
//   Saturated         sticky clip flag for the current block
module sign_result_accumulator #(
    parameter int INPUT_BIT_WIDTH = 8,
    parameter int ACC_BIT_WIDTH   = 16,
    parameter int COUNT_BIT_WIDTH = 4
) (
    input  logic                       Clk,
    input  logic                       ResetN,
    input  logic                       Clear,
    input  logic [COUNT_BIT_WIDTH-1:0] BlockLength,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [INPUT_BIT_WIDTH-1:0] InData,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [ACC_BIT_WIDTH-1:0]   OutSum,
    output logic [COUNT_BIT_WIDTH-1:0] OutCount,
    output logic                       Saturated
);

    localparam int IW = INPUT_BIT_WIDTH;
    localparam int AW = ACC_BIT_WIDTH;
    localparam int CW = COUNT_BIT_WIDTH;

    localparam logic [AW-1:0] MAXV = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] MINV = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] acc;
    logic [CW-1:0] count;
    logic [CW-1:0] len;
    logic          sat;
    logic          ov;

    logic [AW:0]   base_x;
    logic [AW:0]   data_x;
    logic [AW:0]   sum_x;
    logic          clip;
    logic [AW-1:0] sum_sat;
    logic [CW-1:0] len_eff;
    logic [CW-1:0] count_nxt;

    // One guard bit above the accumulator: the top two bits
    // disagreeing means the true sum left the AW-bit range.
    always_comb begin
        base_x  = '0;
        if (state != IDLE)
            base_x = {acc[AW-1], acc};
        data_x  = {{(AW+1-IW){InData[IW-1]}}, InData};
        sum_x   = base_x + data_x;
        clip    = sum_x[AW] ^ sum_x[AW-1];
        sum_sat = sum_x[AW-1:0];
        if (clip)
            sum_sat = sum_x[AW] ? MINV : MAXV;
    end

    assign len_eff   = (BlockLength == '0) ? CW'(1) : BlockLength;
    assign count_nxt = count + CW'(1);

    assign InReady   = (state != HOLD);
    assign OutValid  = ov;
    assign OutSum    = acc;
    assign OutCount  = count;
    assign Saturated = sat;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            len   <= '0;
            sat   <= 1'b0;
            ov    <= 1'b0;
        end else if (Clear) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            len   <= '0;
            sat   <= 1'b0;
            ov    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (InValid) begin
                        len   <= len_eff;
                        acc   <= sum_sat;
                        count <= CW'(1);
                        sat   <= clip;
                        if (len_eff == CW'(1)) begin
                            state <= HOLD;
                            ov    <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (InValid) begin
                        acc   <= sum_sat;
                        count <= count_nxt;
                        sat   <= sat | clip;
                        if (count_nxt == len) begin
                            state <= HOLD;
                            ov    <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (OutReady) begin
                        state <= IDLE;
                        acc   <= '0;
                        count <= '0;
                        sat   <= 1'b0;
                        ov    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ov    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sign_result_accumulator.sv
// Directed bench for sign_result_accumulator.
// Two instances share stimulus: default widths and a 10-bit accumulator.
module tb_sign_result_accumulator;

    logic              Clk;
    logic              ResetN;
    logic              Clear;
    logic [3:0]        BlockLength;
    logic              InValid;
    logic signed [7:0] InData;
    logic              OutReady;

    logic               u0_ir;
    logic               u0_ov;
    logic signed [15:0] u0_sum;
    logic [3:0]         u0_cnt;
    logic               u0_sat;

    logic               u1_ir;
    logic               u1_ov;
    logic signed [9:0]  u1_sum;
    logic [3:0]         u1_cnt;
    logic               u1_sat;

    int checks;
    int failures;

    sign_result_accumulator u0 (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .Clear      (Clear),
        .BlockLength(BlockLength),
        .InValid    (InValid),
        .InReady    (u0_ir),
        .InData     (InData),
        .OutValid   (u0_ov),
        .OutReady   (OutReady),
        .OutSum     (u0_sum),
        .OutCount   (u0_cnt),
        .Saturated  (u0_sat)
    );

    sign_result_accumulator #(
        .ACC_BIT_WIDTH(10)
    ) u1 (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .Clear      (Clear),
        .BlockLength(BlockLength),
        .InValid    (InValid),
        .InReady    (u1_ir),
        .InData     (InData),
        .OutValid   (u1_ov),
        .OutReady   (OutReady),
        .OutSum     (u1_sum),
        .OutCount   (u1_cnt),
        .Saturated  (u1_sat)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic signed [7:0] d);
        InValid = 1'b1;
        InData  = d;
        tick();
        InValid = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        ResetN      = 1'b0;
        Clear       = 1'b0;
        BlockLength = 4'd3;
        InValid     = 1'b0;
        InData      = '0;
        OutReady    = 1'b1;

        #2;
        check("rst_ov", u0_ov, 0);
        check("rst_ir", u0_ir, 1);
        check("rst_sum", u0_sum, 0);
        check("rst_cnt", u0_cnt, 0);
        check("rst_sat", u0_sat, 0);
        #1 ResetN = 1'b1;
        tick();

        // basic block
        InValid = 1'b1;
        InData = 20;  tick();
        InData = -8;  tick();
        InData = 5;   tick();
        InValid = 1'b0;
        check("b_ov", u0_ov, 1);
        check("b_sum", u0_sum, 17);
        check("b_cnt", u0_cnt, 3);
        check("b_sat", u0_sat, 0);
        check("b_ir_hold", u0_ir, 0);
        tick();
        check("b_ov_drop", u0_ov, 0);
        check("b_ir", u0_ir, 1);

        // saturation
        BlockLength = 4'd5;
        InValid = 1'b1;
        InData = 127;
        repeat (5) tick();
        InValid = 1'b0;
        check("sp_ov", u1_ov, 1);
        check("sp_sum", u1_sum, 511);
        check("sp_sat", u1_sat, 1);
        check("sp_wide_sum", u0_sum, 635);
        check("sp_wide_sat", u0_sat, 0);
        tick();
        InValid = 1'b1;
        InData = -128;
        repeat (5) tick();
        InValid = 1'b0;
        check("sn_sum", u1_sum, -512);
        check("sn_sat", u1_sat, 1);
        check("sn_wide_sum", u0_sum, -640);
        tick();
        BlockLength = 4'd2;
        InValid = 1'b1;
        InData = 100;  tick();
        InData = -100; tick();
        InValid = 1'b0;
        check("sz_ov", u1_ov, 1);
        check("sz_sum", u1_sum, 0);
        check("sz_sat", u1_sat, 0);
        tick();

        // backpressure
        OutReady = 1'b0;
        send(7);
        send(9);
        InValid = 1'b1;
        InData  = 3;
        for (int i = 0; i < 4; i++) begin
            check("bp_ov", u0_ov, 1);
            check("bp_sum", u0_sum, 16);
            check("bp_ir", u0_ir, 0);
            tick();
        end
        OutReady = 1'b1;
        tick();
        check("bp_rel_ov", u0_ov, 0);
        check("bp_rel_cnt", u0_cnt, 0);
        tick();
        check("bp_next_cnt", u0_cnt, 1);
        check("bp_next_sum", u0_sum, 3);
        InData = 0;
        tick();
        InValid = 1'b0;
        check("bp_blk_ov", u0_ov, 1);
        check("bp_blk_sum", u0_sum, 3);
        tick();

        // bubbles
        BlockLength = 4'd4;
        for (int i = 1; i <= 4; i++) begin
            send(8'(-i));
            if (i != 4) begin
                tick();
                tick();
            end
        end
        check("bub_ov", u0_ov, 1);
        check("bub_sum", u0_sum, -10);
        check("bub_cnt", u0_cnt, 4);
        tick();

        // zero length acts as one
        BlockLength = 4'd0;
        send(42);
        check("l0_ov", u0_ov, 1);
        check("l0_sum", u0_sum, 42);
        check("l0_cnt", u0_cnt, 1);
        tick();

        // length change mid-block ignored
        BlockLength = 4'd4;
        send(1);
        BlockLength = 4'd1;
        send(1);
        send(1);
        check("lc_ov3", u0_ov, 0);
        check("lc_cnt3", u0_cnt, 3);
        send(1);
        check("lc_ov4", u0_ov, 1);
        check("lc_cnt4", u0_cnt, 4);
        tick();

        // clear mid-block, with a sample offered
        BlockLength = 4'd3;
        send(5);
        send(6);
        Clear   = 1'b1;
        InValid = 1'b1;
        InData  = 9;
        tick();
        Clear   = 1'b0;
        InValid = 1'b0;
        check("clr_ir", u0_ir, 1);
        check("clr_cnt", u0_cnt, 0);
        check("clr_sum", u0_sum, 0);
        OutReady = 1'b0;
        send(1);
        send(1);
        send(1);
        check("clr_blk_sum", u0_sum, 3);
        check("clr_blk_ov", u0_ov, 1);

        // clear in HOLD
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("clrh_ov", u0_ov, 0);
        check("clrh_sum", u0_sum, 0);

        // async reset in HOLD
        BlockLength = 4'd5;
        InValid = 1'b1;
        InData = 127;
        repeat (5) tick();
        InValid = 1'b0;
        check("ar_pre_sat", u1_sat, 1);
        #2 ResetN = 1'b0;
        #1;
        check("ar_ov", u1_ov, 0);
        check("ar_sum", u1_sum, 0);
        check("ar_sat", u1_sat, 0);
        check("ar_ir", u1_ir, 1);
        #1 ResetN = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sign_result_accumulator.md
Name: sign_result_accumulator

Overview:
Downstream consumer of the signed add/sub stage. Takes its signed Result stream over a valid/ready handshake and sums a programmable block of samples into a wider saturating accumulator. It then presents the block sum, the sample count and a saturation flag on an output valid/ready handshake. It is the first stage of the arithmetic result-reduction path.

Parameters:
INPUT_BIT_WIDTH, 8, width of the signed input samples (matches the add/sub Result width)
ACC_BIT_WIDTH, 16, width of the signed accumulator and OutSum; must be >= INPUT_BIT_WIDTH+1
COUNT_BIT_WIDTH, 4, width of BlockLength and OutCount

Ports:
Clk  input  1  clock; all state updates on the rising edge
ResetN  input  1  reset, asynchronous, active-low
Clear  input  1  synchronous abort; returns the block to IDLE
BlockLength  input  COUNT_BIT_WIDTH  samples per block, sampled on the first accepted sample
InValid  input  1  InData is valid
InReady  output  1  block can accept InData this cycle
InData  input  INPUT_BIT_WIDTH  signed sample (add/sub Result)
OutValid  output  1  OutSum, OutCount and Saturated are valid
OutReady  input  1  downstream accepts the output
OutSum  output  ACC_BIT_WIDTH  signed saturated block sum
OutCount  output  COUNT_BIT_WIDTH  number of samples summed
Saturated  output  1  at least one add in this block clipped

Behaviour:
- Reset (ResetN=0, takes effect immediately, no clock needed):
  - state=IDLE; accumulator=0; count=0; stored length=0
  - OutValid=0, OutSum=0, OutCount=0, Saturated=0, InReady=1
- States: IDLE, ACCUM, HOLD.
- Input accept = InValid & InReady. InReady=1 in IDLE and ACCUM, 0 in HOLD.
- IDLE:
  - on accept, latch len = (BlockLength==0 ? 1 : BlockLength)
  - acc = sat(0 + sext(InData)); count=1
  - if len==1 go to HOLD, else go to ACCUM
- ACCUM:
  - on accept, acc = sat(acc + sext(InData)); count=count+1
  - when the new count == len, go to HOLD
  - no accept: hold state and all values
- HOLD:
  - OutValid=1; OutSum=acc; OutCount=count; outputs stable until the handshake
  - OutValid & OutReady: next cycle acc=0, count=0, Saturated=0, OutValid=0, state=IDLE
  - no input accepted in the handshake cycle
- Latency: OutValid rises on the first edge after the cycle in which the final sample is accepted.
- Arithmetic:
  - InData is sign-extended to ACC_BIT_WIDTH+1 bits before the add
  - result above 2^(ACC_BIT_WIDTH-1)-1 clips to max; below -2^(ACC_BIT_WIDTH-1) clips to min
  - any clip sets Saturated; Saturated is sticky until the block completes or is cleared
- BlockLength changes after the first sample of a block have no effect until the next block.
- Clear=1:
  - next edge returns to the reset values, in any state including HOLD
  - OutValid may drop without an OutReady handshake
  - any sample offered in the same cycle is dropped
  - priority: ResetN > Clear > handshake and accumulate
- The count never wraps: the maximum len is 2^COUNT_BIT_WIDTH-1, and HOLD is always reached first.

Test Plan:
1. Basic block (default params): BlockLength=3; InData 20, -8, 5 on consecutive cycles with InValid=1, OutReady=1 → OutValid=1 one cycle after the 5 is accepted, with OutSum=17, OutCount=3, Saturated=0. The next cycle OutValid=0 and InReady=1.
2. Saturation with ACC_BIT_WIDTH=10:
   - BlockLength=5, five samples of 127 → OutSum=511, Saturated=1
   - BlockLength=5, five samples of -128 → OutSum=-512, Saturated=1
   - BlockLength=2, samples 100 and -100 in the next block → OutSum=0, Saturated=0 (sticky flag cleared between blocks)
3. Backpressure: BlockLength=2, samples 7 and 9, OutReady=0 for 4 cycles → OutValid=1, OutSum=16 and InReady=0 held all 4 cycles. InValid is held high with value 3 and is not accepted. After OutReady=1 the 3 becomes the first sample of the next block.
4. Input bubbles and length edge cases:
   - BlockLength=4, samples -1, -2, -3, -4 with InValid low for 2 cycles between samples → OutSum=-10, OutCount=4
   - BlockLength=0, single sample 42 → OutSum=42, OutCount=1
   - BlockLength changed to 1 after the first sample of a 4-sample block → the block still takes 4 samples
5. Clear and reset mid-operation:
   - Clear pulsed after 2 of 3 samples → the next edge gives IDLE, InReady=1; the next 3 samples 1, 1, 1 give OutSum=3
   - Clear asserted in HOLD → OutValid drops without a handshake
   - ResetN pulsed low mid-cycle in HOLD → OutValid, OutSum and Saturated go to 0 before the next Clk edge
